// File: rtl/alu_pkg.sv
// Shared op codes, FSM encoding and flag bit positions for alu_seq.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_EQ  = 4'd6;
  localparam logic [3:0] OP_CLR = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;
  localparam logic [3:0] OP_SRA = 4'd10;
  localparam logic [3:0] OP_LTU = 4'd11;
  localparam logic [3:0] OP_LTS = 4'd12;
  localparam logic [3:0] OP_MUL = 4'd13;

  typedef enum logic {ST_IDLE = 1'b0, ST_MUL = 1'b1} state_t;

  // Bit positions inside the registered flag vector
  localparam int FLG_ZERO  = 0;
  localparam int FLG_NEG   = 1;
  localparam int FLG_CARRY = 2;
  localparam int FLG_OVF   = 3;
  localparam int FLG_ILL   = 4;
  localparam int NFLG      = 5;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial-product step per clock.
// prod/done are combinational views of the step happening this cycle, so the
// caller can capture the final product on the same edge as the last step.
module alu_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   prod
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] p_q;      // {partial high half, remaining multiplier bits}
  logic [WIDTH-1:0]   mcand_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] p_nxt;

  // Add multiplicand into the high half when the current multiplier bit is set, then shift right
  always_comb begin
    sum   = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    p_nxt = {sum, p_q[WIDTH-1:1]};
    done  = (cnt_q == CW'(1));
    prod  = p_nxt;
  end

  // Operand load on start, then WIDTH steps counting down to idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q     <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
    end else if (start) begin
      p_q     <= {{WIDTH{1'b0}}, b};
      mcand_q <= a;
      cnt_q   <= CW'(WIDTH);
    end else if (cnt_q != '0) begin
      p_q     <= p_nxt;
      cnt_q   <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes, status flags and an iterative
// multiply. One operation in flight; single-cycle ops issue back-to-back.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
  output logic             illegal,
  output logic             busy
);
  localparam int SHW = $clog2(WIDTH);

  state_t             state;
  logic [WIDTH-1:0]   res_q;
  logic [NFLG-1:0]    flg_q;
  logic               out_valid_q;
  logic               busy_q;

  logic [SHW-1:0]     sh;
  logic [WIDTH:0]     add_w;
  logic [WIDTH:0]     sub_w;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_v;
  logic               alu_ill;
  logic               is_mul;
  logic               accept;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  // Single-cycle op decode; illegal ops leave result at 0 so zero follows naturally
  always_comb begin
    sh      = b[SHW-1:0];
    add_w   = {1'b0, a} + {1'b0, b};
    sub_w   = {1'b0, a} - {1'b0, b};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ill = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = add_w[WIDTH-1:0];
        alu_c   = add_w[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_w[WIDTH-1:0];
        alu_c   = sub_w[WIDTH];  // borrow == a < b unsigned
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_NOT: alu_res = ~a;
      OP_EQ:  alu_res = {{(WIDTH-1){1'b0}}, a == b};
      OP_CLR: alu_res = '0;
      OP_SHL: alu_res = a << sh;
      OP_SHR: alu_res = a >> sh;
      OP_SRA: alu_res = $unsigned($signed(a) >>> sh);
      OP_LTU: alu_res = {{(WIDTH-1){1'b0}}, a < b};
      OP_LTS: alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      default: alu_ill = 1'b1;  // 14, 15, and MUL when the multiplier is disabled
    endcase
  end

  // Handshake: accept only when idle and the output slot is free or draining
  always_comb begin
    is_mul   = MUL_EN && (op == OP_MUL);
    in_ready = rst_n && (state == ST_IDLE) && (!out_valid_q || out_ready);
    accept   = in_valid && in_ready;
  end

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept && is_mul),
    .a     (a),
    .b     (b),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  // Control FSM plus output register: latency-1 ops in IDLE, multiply completion in MUL
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      flg_q       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_mul) begin
              state       <= ST_MUL;
              busy_q      <= 1'b1;
              out_valid_q <= 1'b0;
            end else begin
              out_valid_q      <= 1'b1;
              res_q            <= alu_res;
              flg_q[FLG_ZERO]  <= (alu_res == '0);
              flg_q[FLG_NEG]   <= alu_res[WIDTH-1];
              flg_q[FLG_CARRY] <= alu_c;
              flg_q[FLG_OVF]   <= alu_v;
              flg_q[FLG_ILL]   <= alu_ill;
            end
          end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            state            <= ST_IDLE;
            busy_q           <= 1'b0;
            out_valid_q      <= 1'b1;
            res_q            <= mul_prod[WIDTH-1:0];
            flg_q[FLG_ZERO]  <= (mul_prod[WIDTH-1:0] == '0);
            flg_q[FLG_NEG]   <= mul_prod[WIDTH-1];
            flg_q[FLG_CARRY] <= 1'b0;
            flg_q[FLG_OVF]   <= (mul_prod[2*WIDTH-1:WIDTH] != '0);
            flg_q[FLG_ILL]   <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign result    = res_q;
  assign zero      = flg_q[FLG_ZERO];
  assign negative  = flg_q[FLG_NEG];
  assign carry     = flg_q[FLG_CARRY];
  assign overflow  = flg_q[FLG_OVF];
  assign illegal   = flg_q[FLG_ILL];
  assign busy      = busy_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: main 8-bit instance, an 8-bit instance without
// the multiplier, and a 16-bit instance sharing the control inputs.
module tb_alu_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready;
  logic [3:0]  op;
  logic [7:0]  a, b;
  logic [15:0] a16, b16;

  logic        m_in_ready, m_out_valid, m_zero, m_negative, m_carry, m_overflow, m_illegal, m_busy;
  logic [7:0]  m_result;
  logic        n_in_ready, n_out_valid, n_zero, n_negative, n_carry, n_overflow, n_illegal, n_busy;
  logic [7:0]  n_result;
  logic        w_in_ready, w_out_valid, w_zero, w_negative, w_carry, w_overflow, w_illegal, w_busy;
  logic [15:0] w_result;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(8), .MUL_EN(1'b1)) u_main (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(m_in_ready),
    .a(a), .b(b), .op(op), .out_valid(m_out_valid), .out_ready(out_ready),
    .result(m_result), .zero(m_zero), .negative(m_negative), .carry(m_carry),
    .overflow(m_overflow), .illegal(m_illegal), .busy(m_busy));

  alu_seq #(.WIDTH(8), .MUL_EN(1'b0)) u_nomul (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(n_in_ready),
    .a(a), .b(b), .op(op), .out_valid(n_out_valid), .out_ready(out_ready),
    .result(n_result), .zero(n_zero), .negative(n_negative), .carry(n_carry),
    .overflow(n_overflow), .illegal(n_illegal), .busy(n_busy));

  alu_seq #(.WIDTH(16), .MUL_EN(1'b1)) u_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
    .a(a16), .b(b16), .op(op), .out_valid(w_out_valid), .out_ready(out_ready),
    .result(w_result), .zero(w_zero), .negative(w_negative), .carry(w_carry),
    .overflow(w_overflow), .illegal(w_illegal), .busy(w_busy));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = 4'd0;
    a = 8'h00; b = 8'h00; a16 = 16'h0; b16 = 16'h0;
    #2;
    n_chk++; if ({m_out_valid, m_busy, m_in_ready} !== 3'b000) begin n_fail++;
      $display("FAIL reset_ctrl: got %b want 000", {m_out_valid, m_busy, m_in_ready}); end
    n_chk++; if (m_result !== 8'h00) begin n_fail++;
      $display("FAIL reset_result: got %h want 00", m_result); end
    n_chk++; if ({m_zero, m_negative, m_carry, m_overflow, m_illegal} !== 5'b0) begin n_fail++;
      $display("FAIL reset_flags: got %b want 00000", {m_zero, m_negative, m_carry, m_overflow, m_illegal}); end
    repeat (2) tick();
    rst_n = 1'b1;
    #1;
    n_chk++; if (m_in_ready !== 1'b1) begin n_fail++;
      $display("FAIL reset_release_ready: got %b want 1", m_in_ready); end
  endtask

  task automatic test_add();
    op = 4'd0; a = 8'hFF; b = 8'h01; in_valid = 1'b1;
    n_chk++; if (m_out_valid !== 1'b0) begin n_fail++;
      $display("FAIL add_pre_valid: got %b want 0", m_out_valid); end
    tick();
    in_valid = 1'b0;
    n_chk++; if (m_out_valid !== 1'b1) begin n_fail++;
      $display("FAIL add_latency: got %b want 1", m_out_valid); end
    n_chk++; if (m_result !== 8'h00) begin n_fail++;
      $display("FAIL add_result: got %h want 00", m_result); end
    n_chk++; if ({m_zero, m_carry, m_overflow} !== 3'b110) begin n_fail++;
      $display("FAIL add_flags(z,c,v): got %b want 110", {m_zero, m_carry, m_overflow}); end
    tick();
    n_chk++; if (m_out_valid !== 1'b0) begin n_fail++;
      $display("FAIL add_drain: got %b want 0", m_out_valid); end
  endtask

  task automatic test_sub_lts();
    op = 4'd1; a = 8'h80; b = 8'h01; in_valid = 1'b1;
    tick();
    n_chk++; if (m_result !== 8'h7F) begin n_fail++;
      $display("FAIL sub_result: got %h want 7f", m_result); end
    n_chk++; if ({m_overflow, m_carry, m_negative} !== 3'b100) begin n_fail++;
      $display("FAIL sub_flags(v,c,n): got %b want 100", {m_overflow, m_carry, m_negative}); end
    op = 4'd12; a = 8'h80; b = 8'h01;
    tick();
    in_valid = 1'b0;
    n_chk++; if ({m_out_valid, m_result} !== {1'b1, 8'h01}) begin n_fail++;
      $display("FAIL lts_b2b: got %b/%h want 1/01", m_out_valid, m_result); end
    tick();
  endtask

  task automatic test_mul();
    op = 4'd0; a = 8'h01; b = 8'h01; in_valid = 1'b1;
    tick();
    op = 4'd13; a = 8'h0F; b = 8'h11;
    n_chk++; if ({m_out_valid, m_in_ready} !== 2'b11) begin n_fail++;
      $display("FAIL mul_pre(valid,ready): got %b want 11", {m_out_valid, m_in_ready}); end
    tick();
    in_valid = 1'b0;
    n_chk++; if ({m_busy, m_out_valid, m_in_ready} !== 3'b100) begin n_fail++;
      $display("FAIL mul_start(busy,valid,ready): got %b want 100", {m_busy, m_out_valid, m_in_ready}); end
    n_chk++; if ({n_out_valid, n_illegal, n_zero, n_result} !== {3'b111, 8'h00}) begin n_fail++;
      $display("FAIL nomul_illegal: got %b%b%b/%h want 111/00", n_out_valid, n_illegal, n_zero, n_result); end
    for (int k = 1; k < 8; k++) begin
      tick();
      n_chk++; if ({m_busy, m_out_valid, m_in_ready} !== 3'b100) begin n_fail++;
        $display("FAIL mul_step%0d(busy,valid,ready): got %b want 100", k, {m_busy, m_out_valid, m_in_ready}); end
    end
    tick();
    n_chk++; if ({m_busy, m_out_valid} !== 2'b01) begin n_fail++;
      $display("FAIL mul_done(busy,valid): got %b want 01", {m_busy, m_out_valid}); end
    n_chk++; if ({m_result, m_overflow, m_zero} !== {8'hFF, 2'b00}) begin n_fail++;
      $display("FAIL mul_0f_11: got %h v%b z%b want ff v0 z0", m_result, m_overflow, m_zero); end
    op = 4'd13; a = 8'h10; b = 8'h10; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (8) tick();
    n_chk++; if ({m_out_valid, m_result, m_zero, m_overflow} !== {1'b1, 8'h00, 2'b11}) begin n_fail++;
      $display("FAIL mul_10_10: got %b/%h z%b v%b want 1/00 z1 v1", m_out_valid, m_result, m_zero, m_overflow); end
    tick();
  endtask

  task automatic test_hold_b2b();
    out_ready = 1'b0;
    op = 4'd0; a = 8'h0A; b = 8'h05; in_valid = 1'b1;
    tick();
    op = 4'd4; a = 8'hFF; b = 8'h0F;
    for (int k = 0; k < 3; k++) begin
      n_chk++; if ({m_out_valid, m_in_ready, m_result} !== {2'b10, 8'h0F}) begin n_fail++;
        $display("FAIL hold_cyc%0d: got %b%b/%h want 10/0f", k, m_out_valid, m_in_ready, m_result); end
      if (k < 2) tick();
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n_chk++; if ({m_out_valid, m_result, m_negative} !== {1'b1, 8'hF0, 1'b1}) begin n_fail++;
      $display("FAIL hold_xor_b2b: got %b/%h n%b want 1/f0 n1", m_out_valid, m_result, m_negative); end
    tick();
    n_chk++; if (m_out_valid !== 1'b0) begin n_fail++;
      $display("FAIL hold_drain: got %b want 0", m_out_valid); end
  endtask

  task automatic test_reset_mid_mul();
    op = 4'd13; a = 8'h03; b = 8'h05; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    n_chk++; if (m_busy !== 1'b1) begin n_fail++;
      $display("FAIL rmul_busy_before: got %b want 1", m_busy); end
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if ({m_out_valid, m_busy, m_in_ready} !== 3'b000) begin n_fail++;
      $display("FAIL rmul_async(valid,busy,ready): got %b want 000", {m_out_valid, m_busy, m_in_ready}); end
    tick();
    rst_n = 1'b1;
    #1;
    n_chk++; if ({m_in_ready, m_out_valid, m_busy} !== 3'b100) begin n_fail++;
      $display("FAIL rmul_release(ready,valid,busy): got %b want 100", {m_in_ready, m_out_valid, m_busy}); end
    for (int k = 0; k < 10; k++) begin
      tick();
      n_chk++; if (m_out_valid !== 1'b0) begin n_fail++;
        $display("FAIL rmul_stale%0d: got %b want 0", k, m_out_valid); end
    end
  endtask

  task automatic test_ops_table();
    logic [3:0] t_op  [14] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd14, 4'd15};
    logic [7:0] t_a   [14] = '{8'hF0, 8'hF0, 8'hF0, 8'h0F, 8'h5A, 8'h5A, 8'h12, 8'h81, 8'h81, 8'h80, 8'h01, 8'h01, 8'h33, 8'hFF};
    logic [7:0] t_b   [14] = '{8'h3C, 8'h3C, 8'h3C, 8'h00, 8'h5A, 8'h5B, 8'h34, 8'h09, 8'h04, 8'h03, 8'h80, 8'h80, 8'h44, 8'hFF};
    logic [7:0] t_exp [14] = '{8'h30, 8'hFC, 8'hCC, 8'hF0, 8'h01, 8'h00, 8'h00, 8'h02, 8'h08, 8'hF0, 8'h01, 8'h00, 8'h00, 8'h00};
    logic       t_ill [14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] e;
    for (int i = 0; i < 14; i++) begin
      op = t_op[i]; a = t_a[i]; b = t_b[i]; in_valid = 1'b1;
      tick();
      e = t_exp[i];
      n_chk++; if ({m_out_valid, m_result} !== {1'b1, e}) begin n_fail++;
        $display("FAIL op%0d_result: got %b/%h want 1/%h", t_op[i], m_out_valid, m_result, e); end
      n_chk++; if ({m_illegal, m_zero, m_negative, m_carry, m_overflow} !== {t_ill[i], e == 8'h00, e[7], 2'b00}) begin n_fail++;
        $display("FAIL op%0d_flags(i,z,n,c,v): got %b want %b", t_op[i],
                 {m_illegal, m_zero, m_negative, m_carry, m_overflow}, {t_ill[i], e == 8'h00, e[7], 2'b00}); end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_w16();
    int k = 0;
    while (!w_in_ready && k < 40) begin tick(); k++; end
    n_chk++; if (w_in_ready !== 1'b1) begin n_fail++;
      $display("FAIL w16_ready_timeout: got %b want 1", w_in_ready); end
    op = 4'd13; a16 = 16'h1234; b16 = 16'h0010; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (15) tick();
    n_chk++; if ({w_busy, w_out_valid} !== 2'b10) begin n_fail++;
      $display("FAIL w16_mul_step15(busy,valid): got %b want 10", {w_busy, w_out_valid}); end
    tick();
    n_chk++; if ({w_busy, w_out_valid, w_result, w_overflow} !== {2'b01, 16'h2340, 1'b1}) begin n_fail++;
      $display("FAIL w16_mul_ovf: got %b%b/%h v%b want 01/2340 v1", w_busy, w_out_valid, w_result, w_overflow); end
    op = 4'd13; a16 = 16'h00FF; b16 = 16'h0101; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (16) tick();
    n_chk++; if ({w_out_valid, w_result, w_overflow, w_negative} !== {1'b1, 16'hFFFF, 2'b01}) begin n_fail++;
      $display("FAIL w16_mul_ffff: got %b/%h v%b n%b want 1/ffff v0 n1", w_out_valid, w_result, w_overflow, w_negative); end
    op = 4'd0; a16 = 16'hFFFF; b16 = 16'h0001; in_valid = 1'b1;
    tick();
    n_chk++; if ({w_result, w_zero, w_carry, w_overflow} !== {16'h0000, 3'b110}) begin n_fail++;
      $display("FAIL w16_add: got %h z%b c%b v%b want 0000 z1 c1 v0", w_result, w_zero, w_carry, w_overflow); end
    op = 4'd10; a16 = 16'h8000; b16 = 16'h0004;
    tick();
    in_valid = 1'b0;
    n_chk++; if ({w_result, w_negative} !== {16'hF800, 1'b1}) begin n_fail++;
      $display("FAIL w16_sra: got %h n%b want f800 n1", w_result, w_negative); end
    tick();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_lts();
    test_mul();
    test_hold_b2b();
    test_reset_mid_mul();
    test_ops_table();
    test_w16();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
